// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, with signed/unsigned modes.
// A valid/ready handshake applies on both the operand and the result side.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              dvd_neg_q, dvd_neg_d;
    logic              dvs_neg_q, dvs_neg_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              div_zero_q, div_zero_d;
    logic              overflow_q, overflow_d;

    // Shifted partial remainder needs WIDTH+1 bits so full-range unsigned magnitudes are exact.
    logic [WIDTH:0]    rem_sh;
    logic              ge;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        rem_sh      = {rem_q, quo_q[WIDTH-1]};
        ge          = (rem_sh >= {1'b0, dvs_q});

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvd_neg_d = signed_i & dividend[WIDTH-1];
                    dvs_neg_d = signed_i & divisor[WIDTH-1];
                    quo_d     = dvd_neg_d ? (-dividend) : dividend;
                    dvs_d     = dvs_neg_d ? (-divisor) : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = signed_i && (dividend == MinNeg) && (divisor == '1);
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        overflow_d  = 1'b0;
                        state_d     = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Subtraction fits WIDTH bits: the result is always below the divisor magnitude.
                rem_d = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? (-quo_q) : quo_q;
                remainder_d = dvd_neg_q ? (-rem_q) : rem_q;
                div_zero_d  = 1'b0;
                overflow_d  = ovf_q;
                state_d     = StDone;
            end
            StDone: begin
                // out_valid lags DONE entry by one edge and drops on the handshake edge.
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): directed vectors push expectations,
// and a monitor checks each result as out_valid rises.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       signed_i;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       overflow;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic ov_prev = 1'b0;

    seq_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .signed_i  (signed_i),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison set per rising out_valid.
    always @(negedge clk) begin
        if (rst_n && out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(mon_e.q));
                chk("remainder", 32'(remainder), 32'(mon_e.r));
                chk("div_zero", 32'(div_zero), 32'(mon_e.dz));
                chk("overflow", 32'(overflow), 32'(mon_e.ov));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
        ov_prev <= out_valid;
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov, input int lat);
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        signed_i = s;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        // Operands change after acceptance; they must not affect the result.
        signed_i = 1'($urandom);
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        signed_i  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", 32'({div_zero, overflow}), 32'd0);

        issue(1'b0, 8'd13,  8'd4,  8'h03, 8'h01, 1'b0, 1'b0, 10);
        issue(1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10);
        issue(1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 10);
        issue(1'b1, 8'hF9,  8'hFE, 8'h03, 8'hFF, 1'b0, 1'b0, 10);
        issue(1'b0, 8'hF9,  8'h02, 8'h7C, 8'h01, 1'b0, 1'b0, 10);
        issue(1'b0, 8'h25,  8'h00, 8'hFF, 8'h25, 1'b1, 1'b0, 1);
        issue(1'b1, 8'h25,  8'h00, 8'hFF, 8'h25, 1'b1, 1'b0, 1);
        issue(1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10);
        issue(1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 10);
        issue(1'b1, 8'h80,  8'h02, 8'hC0, 8'h00, 1'b0, 1'b0, 10);
        issue(1'b0, 8'hFF,  8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 10);

        // Back-pressure: result held while in_valid pulses with new operands.
        wait_ready();
        out_ready = 1'b0;
        issue(1'b0, 8'd13, 8'd4, 8'h03, 8'h01, 1'b0, 1'b0, 10);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0] ? 1'b0 : 1'b1;
            signed_i = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'h01;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_quotient", 32'(quotient), 32'h03);
            chk("hold_remainder", 32'(remainder), 32'h01);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        chk("no_stray_accept", 32'(out_valid), 32'd0);

        // Reset in the middle of CALC; the in-flight operation is discarded.
        wait_ready();
        in_valid = 1'b1;
        signed_i = 1'b0;
        dividend = 8'h55;
        divisor  = 8'h03;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_quotient", 32'(quotient), 32'd0);
        chk("post_rst_remainder", 32'(remainder), 32'd0);
        issue(1'b0, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 10);

        for (int i = 0; i < 400 && (sb.size() != 0 || !in_ready); i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
